// File: rtl/sr_latch_bank.sv
// ---------------------------------------------------------------------------
// sr_latch_bank
//
// Bank of N independent, clocked set/reset state bits. Each channel has its
// own enable. The s=r=1 case follows a compile-time policy (hold, set,
// reset or toggle). The block also produces registered one-cycle edge pulses
// per channel and a sticky conflict flag with a saturating conflict-cycle
// counter.
//
// Parameters:
//   N             number of channels (1..32)
//   CONFLICT_MODE s=r=1 policy: 0 hold, 1 set, 2 reset, 3 toggle
//   RST_VAL       value loaded into q on reset
//   CNT_W         width of conflict_cnt
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset, overrides every other input
//   en[N]         per-channel enable, a disabled channel holds and never
//                 counts as a conflict
//   s[N], r[N]    per-channel set / reset requests
//   clr_conflict  clears conflict and conflict_cnt unless a conflict occurs
//                 in the same cycle
//   q[N]          registered state bits
//   q_rise[N]     one-cycle pulse aligned with the first cycle of q[i]=1
//   q_fall[N]     one-cycle pulse aligned with the first cycle of q[i]=0
//   conflict      sticky flag, some enabled channel saw s=r=1
//   conflict_cnt  saturating count of cycles with at least one conflict
// ---------------------------------------------------------------------------
module sr_latch_bank #(
    parameter int            N             = 8,
    parameter int            CONFLICT_MODE = 0,
    parameter logic [N-1:0]  RST_VAL       = {N{1'b0}},
    parameter int            CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             clr_conflict,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_rise,
    output logic [N-1:0]     q_fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0]       MODE    = 2'(CONFLICT_MODE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]     q_r;
    logic [N-1:0]     q_rise_r;
    logic [N-1:0]     q_fall_r;
    logic             conflict_r;
    logic [CNT_W-1:0] cnt_r;

    logic [N-1:0]     q_next_s;
    logic             event_s;
    logic             conflict_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Next value of one enabled channel; the s=r=1 case never yields X.
    function automatic logic next_bit(input logic cur, input logic set_i,
                                      input logic rst_i);
        logic nb;
        case ({set_i, rst_i})
            2'b00: nb = cur;
            2'b01: nb = 1'b0;
            2'b10: nb = 1'b1;
            2'b11: begin
                case (MODE)
                    2'd0:    nb = cur;
                    2'd1:    nb = 1'b1;
                    2'd2:    nb = 1'b0;
                    2'd3:    nb = ~cur;
                    default: nb = cur;
                endcase
            end
            default: nb = cur;
        endcase
        return nb;
    endfunction

    // Per-channel next state; disabled channels hold.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                q_next_s[i] = next_bit(q_r[i], s[i], r[i]);
            end else begin
                q_next_s[i] = q_r[i];
            end
        end
    end

    // Conflict flag/counter update; a same-cycle event beats clr_conflict.
    always_comb begin
        event_s         = |(en & s & r);
        conflict_next_s = conflict_r;
        cnt_next_s      = cnt_r;
        if (event_s) begin
            conflict_next_s = 1'b1;
            if (clr_conflict) begin
                cnt_next_s = CNT_ONE;
            end else if (cnt_r == CNT_MAX) begin
                cnt_next_s = CNT_MAX;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else if (clr_conflict) begin
            conflict_next_s = 1'b0;
            cnt_next_s      = {CNT_W{1'b0}};
        end else begin
            conflict_next_s = conflict_r;
            cnt_next_s      = cnt_r;
        end
    end

    // State, edge-pulse and conflict registers; reset never produces pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= RST_VAL;
            q_rise_r   <= {N{1'b0}};
            q_fall_r   <= {N{1'b0}};
            conflict_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            q_r        <= q_next_s;
            q_rise_r   <= q_next_s & ~q_r;
            q_fall_r   <= ~q_next_s & q_r;
            conflict_r <= conflict_next_s;
            cnt_r      <= cnt_next_s;
        end
    end

    assign q            = q_r;
    assign q_rise       = q_rise_r;
    assign q_fall       = q_fall_r;
    assign conflict     = conflict_r;
    assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: five instances share one stimulus stream
// (modes 0..3 with an 8-bit counter, plus mode 0 with a 3-bit counter),
// all checked every cycle against a per-channel reference model.
module tb_sr_latch_bank;

    logic       clk;
    logic       rst;
    logic [7:0] en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;

    logic [7:0] q_o    [5];
    logic [7:0] rise_o [5];
    logic [7:0] fall_o [5];
    logic       conf_o [5];
    logic [7:0] cnt_o  [4];
    logic [2:0] cnt3;

    int errors;
    int checks;

    // reference model state
    logic [7:0] mq    [5];
    logic [7:0] mrise [5];
    logic [7:0] mfall [5];
    logic       mconf [5];
    int         mcnt  [5];

    typedef struct {
        logic       rst;
        logic [7:0] en;
        logic [7:0] s;
        logic [7:0] r;
        logic       clr;
        logic [7:0] eq;
        logic [7:0] erise;
        logic [7:0] efall;
        logic       econf;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sr_latch_bank #(.N(8), .CONFLICT_MODE(0), .RST_VAL(8'hA5), .CNT_W(8)) u_m0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
        .q(q_o[0]), .q_rise(rise_o[0]), .q_fall(fall_o[0]),
        .conflict(conf_o[0]), .conflict_cnt(cnt_o[0]));
    sr_latch_bank #(.N(8), .CONFLICT_MODE(1), .RST_VAL(8'hA5), .CNT_W(8)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
        .q(q_o[1]), .q_rise(rise_o[1]), .q_fall(fall_o[1]),
        .conflict(conf_o[1]), .conflict_cnt(cnt_o[1]));
    sr_latch_bank #(.N(8), .CONFLICT_MODE(2), .RST_VAL(8'hA5), .CNT_W(8)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
        .q(q_o[2]), .q_rise(rise_o[2]), .q_fall(fall_o[2]),
        .conflict(conf_o[2]), .conflict_cnt(cnt_o[2]));
    sr_latch_bank #(.N(8), .CONFLICT_MODE(3), .RST_VAL(8'hA5), .CNT_W(8)) u_m3 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
        .q(q_o[3]), .q_rise(rise_o[3]), .q_fall(fall_o[3]),
        .conflict(conf_o[3]), .conflict_cnt(cnt_o[3]));
    sr_latch_bank #(.N(8), .CONFLICT_MODE(0), .RST_VAL(8'hA5), .CNT_W(3)) u_c3 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
        .q(q_o[4]), .q_rise(rise_o[4]), .q_fall(fall_o[4]),
        .conflict(conf_o[4]), .conflict_cnt(cnt3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one cycle from the current inputs.
    task automatic model_step();
        for (int k = 0; k < 5; k++) begin
            int mode;
            int cap;
            logic [7:0] nq;
            bit ev;
            mode = (k < 4) ? k : 0;
            cap  = (k < 4) ? 255 : 7;
            if (rst) begin
                mq[k] = 8'hA5; mrise[k] = 8'h00; mfall[k] = 8'h00;
                mconf[k] = 1'b0; mcnt[k] = 0;
            end else begin
                nq = mq[k];
                ev = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (en[i]) begin
                        if (s[i] && !r[i]) nq[i] = 1'b1;
                        else if (!s[i] && r[i]) nq[i] = 1'b0;
                        else if (s[i] && r[i]) begin
                            ev = 1'b1;
                            if (mode == 1) nq[i] = 1'b1;
                            else if (mode == 2) nq[i] = 1'b0;
                            else if (mode == 3) nq[i] = ~mq[k][i];
                        end
                    end
                end
                mrise[k] = nq & ~mq[k];
                mfall[k] = ~nq & mq[k];
                mq[k]    = nq;
                if (ev) begin
                    mconf[k] = 1'b1;
                    mcnt[k]  = clr ? 1 : ((mcnt[k] + 1 > cap) ? cap : mcnt[k] + 1);
                end else if (clr) begin
                    mconf[k] = 1'b0;
                    mcnt[k]  = 0;
                end
            end
        end
    endtask

    // One clock: update model, let the DUT take the edge, compare #1 later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("inst%0d q", k), 32'(q_o[k]), 32'(mq[k]));
            chk($sformatf("inst%0d q_rise", k), 32'(rise_o[k]), 32'(mrise[k]));
            chk($sformatf("inst%0d q_fall", k), 32'(fall_o[k]), 32'(mfall[k]));
            chk($sformatf("inst%0d conflict", k), 32'(conf_o[k]), 32'(mconf[k]));
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("inst%0d conflict_cnt", k), 32'(cnt_o[k]), 32'(mcnt[k]));
        chk("inst4 conflict_cnt", 32'(cnt3), 32'(mcnt[4]));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; en = 8'h00; s = 8'h00; r = 8'h00; clr = 1'b0;

        //         rst   en     s      r      clr   q      rise   fall   cf    cnt
        tbl[0]  = '{1'b1, 8'hFF, 8'h3C, 8'hC3, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 8'hA4, 8'h00, 8'h01, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b0, 8'hA5, 8'h01, 8'h00, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 8'hA4, 8'h00, 8'h01, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 8'hA4, 8'h00, 8'h00, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 8'hFF, 8'h22, 8'h22, 1'b0, 8'hA4, 8'h00, 8'h00, 1'b1, 8'd1};
        tbl[6]  = '{1'b0, 8'hFF, 8'h04, 8'h04, 1'b0, 8'hA4, 8'h00, 8'h00, 1'b1, 8'd2};
        tbl[7]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'hA4, 8'h00, 8'h00, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 8'hFF, 8'h08, 8'h08, 1'b1, 8'hA4, 8'h00, 8'h00, 1'b1, 8'd1};
        tbl[9]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'hA4, 8'h00, 8'h00, 1'b1, 8'd1};
        tbl[10] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 8'd0};

        // directed table, expectations for the mode-0 instance
        for (int v = 0; v < 12; v++) begin
            rst = tbl[v].rst; en = tbl[v].en; s = tbl[v].s; r = tbl[v].r; clr = tbl[v].clr;
            tick();
            chk($sformatf("tbl%0d q", v), 32'(q_o[0]), 32'(tbl[v].eq));
            chk($sformatf("tbl%0d q_rise", v), 32'(rise_o[0]), 32'(tbl[v].erise));
            chk($sformatf("tbl%0d q_fall", v), 32'(fall_o[0]), 32'(tbl[v].efall));
            chk($sformatf("tbl%0d conflict", v), 32'(conf_o[0]), 32'(tbl[v].econf));
            chk($sformatf("tbl%0d conflict_cnt", v), 32'(cnt_o[0]), 32'(tbl[v].ecnt));
        end

        // s=r=1 on channel 3 for three cycles, q[3] starts at 0
        rst = 1'b0; clr = 1'b0; en = 8'h08; s = 8'h08; r = 8'h08;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk($sformatf("toggle rise t%0d", t), 32'(rise_o[3][3]), 32'(t % 2));
            chk($sformatf("toggle fall t%0d", t), 32'(fall_o[3][3]), 32'(1 - (t % 2)));
        end
        chk("mode0 q3", 32'(q_o[0][3]), 32'd0);
        chk("mode1 q3", 32'(q_o[1][3]), 32'd1);
        chk("mode2 q3", 32'(q_o[2][3]), 32'd0);
        chk("mode3 q3", 32'(q_o[3][3]), 32'd1);

        // counter saturation with CNT_W=3
        rst = 1'b1; en = 8'h00; s = 8'h00; r = 8'h00;
        tick();
        rst = 1'b0; en = 8'h01; s = 8'h01; r = 8'h01;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk($sformatf("sat cnt3 t%0d", t), 32'(cnt3), 32'((t < 7) ? t : 7));
            chk($sformatf("sat cnt8 t%0d", t), 32'(cnt_o[0]), 32'(t));
        end
        en = 8'h00; s = 8'hFF; r = 8'hFF;
        tick();
        chk("disabled conflict cnt3", 32'(cnt3), 32'd7);
        chk("disabled conflict cnt8", 32'(cnt_o[0]), 32'd10);

        // randomized stream against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 7) == 0);
            en  = 8'($urandom);
            s   = 8'($urandom);
            r   = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised, clocked successor to the team's single-bit set/reset latch. The block holds N independent set/reset state bits, each with its own enable and a selectable policy for the s=r=1 conflict case. It also produces per-channel edge pulses and a sticky conflict flag with a saturating conflict-cycle counter. It is used wherever the design needs a bank of registered flags driven by set/clear requests, such as status, interrupt-pending or arming bits.

## Interface
- N, default 8: number of channels (1..32).
- CONFLICT_MODE, default 0: s=r=1 policy. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- RST_VAL, default {N{1'b0}}: value loaded into q on reset.
- CNT_W, default 8: width of conflict_cnt.
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  reset. Synchronous and active-high, sampled on the rising edge of clk.
- en  input  N  per-channel enable. When en[i]=0, channel i holds and no conflict is recorded for it.
- s  input  N  per-channel set request.
- r  input  N  per-channel reset request.
- clr_conflict  input  1  clears conflict and conflict_cnt.
- q  output  N  registered state bits.
- q_rise  output  N  one-cycle pulse in the cycle after q[i] went 0->1.
- q_fall  output  N  one-cycle pulse in the cycle after q[i] went 1->0.
- conflict  output  1  sticky flag: some enabled channel saw s=r=1.
- conflict_cnt  output  CNT_W  number of cycles with at least one enabled conflict. Saturates at all-ones.

## Operation
- Next-state rule per channel i, applied only when en[i]=1:
  - {s,r} = 00: hold.
  - {s,r} = 01: q <= 0.
  - {s,r} = 10: q <= 1.
  - {s,r} = 11: follow CONFLICT_MODE (hold / 1 / 0 / ~q).
- en[i]=0: q[i] holds regardless of s[i] and r[i].
- No X is ever assigned. The undefined-output case of the single-bit latch is replaced by the defined CONFLICT_MODE behaviour.
- Conflict event: any i with en[i] & s[i] & r[i] in the current cycle.
  - On an event, conflict <= 1 and conflict_cnt increments by 1 per cycle, regardless of how many channels conflict.
  - At all-ones, conflict_cnt stays all-ones.
- clr_conflict=1 with no event in the same cycle: conflict <= 0, conflict_cnt <= 0.
- clr_conflict=1 together with an event in the same cycle: the event wins, so conflict <= 1 and conflict_cnt <= 1.
- q_rise and q_fall are computed from the next and current q and registered on the same edge that updates q. They are therefore aligned with the first cycle of the new q value.
- Reset, at any time including mid-operation, takes priority over every other input:
  - q <= RST_VAL.
  - q_rise <= 0, q_fall <= 0.
  - conflict <= 0, conflict_cnt <= 0.
- Reset never generates edge pulses, even when RST_VAL differs from the pre-reset q.
- Channels are fully independent. No cross-channel priority exists except the shared conflict counting.

## Timing
- Latency: one cycle. Inputs sampled at edge k appear on q at edge k (visible after edge k). q_rise and q_fall are valid in the same cycle as the new q.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Edge pulses last exactly one cycle. A channel toggling every cycle (CONFLICT_MODE=3, s=r=1 held) alternates q_rise and q_fall every cycle.
- The cycle after rst deasserts behaves normally. An input applied in the same edge as the rst deassertion is not sampled.
- conflict_cnt reaches its saturated value 2^CNT_W-1 after that many conflict cycles and holds it from then on.

## Test plan
- Reset with RST_VAL=8'hA5 and random s/r/en -> q=8'hA5, q_rise=q_fall=0, conflict=0, conflict_cnt=0. Repeat with reset asserted mid-stream: same values and no pulses.
- Channel 0 with en=1, s=1 for one cycle, then r=1 for one cycle -> q[0] goes 1 then 0. q_rise[0] and q_fall[0] each pulse once, aligned with the q change. With en[0]=0 the same stimulus leaves q[0] unchanged.
- s=r=1 on channel 3, run once per mode (0 hold, 1 set, 2 reset, 3 toggle), starting from q[3]=0:
  - After 3 cycles q[3] = 0 / 1 / 0 / 1 respectively.
  - In mode 3, q_rise and q_fall alternate each cycle.
- Conflicts on channels 1 and 5 in the same cycle, then on channel 2 the next cycle -> conflict=1, conflict_cnt=2. Assert clr_conflict alone -> both return to 0. Assert clr_conflict together with a new conflict -> conflict=1, conflict_cnt=1.
- CNT_W=3, hold a conflict for 10 cycles -> conflict_cnt reaches 7 and stays at 7. A conflict with en[i]=0 does not count.
